// File: rtl/shift_seq_if.sv
// Request/response handshake bundle between shift_seq and its requester/consumer.
// master = requester side, slave = shift_seq.
interface shift_seq_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = 3
);
   localparam int unsigned OP_W = 3;

   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  in_op;
   logic [WIDTH-1:0] in_data;
   logic [AMT_W-1:0] in_amount;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_err;

   modport master (
      output in_valid, in_op, in_data, in_amount, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_op, in_data, in_amount, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/shift_seq.sv
// Multi-pass sequencer in front of the 8-bit shifter: builds rotates and arithmetic
// right shifts by ORing up to two shifter passes into an accumulator.
module shift_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = 3
) (
   input  logic             clk,
   input  logic             clear_n,
   shift_seq_if.slave       bus,
   output logic [WIDTH-1:0] sh_data,
   output logic [AMT_W-1:0] sh_amount,
   output logic             sh_direction,
   input  logic [WIDTH-1:0] sh_result,
   output logic             busy
);
   localparam int unsigned     OP_W   = 3;
   localparam logic [OP_W-1:0] OP_LSL = 3'b000;
   localparam logic [OP_W-1:0] OP_ROL = 3'b010;
   localparam logic [OP_W-1:0] OP_ROR = 3'b011;
   localparam logic [OP_W-1:0] OP_ASR = 3'b100;

   typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [AMT_W-1:0] amt_q, amt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_err_q, out_err_d;
   logic [WIDTH-1:0] sh_data_q, sh_data_d;
   logic [AMT_W-1:0] sh_amount_q, sh_amount_d;
   logic             sh_dir_q, sh_dir_d;
   logic             busy_q, busy_d;
   logic [AMT_W:0]   amt_comp;
   logic             two_pass;

   // Next state, accumulator and output register update
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      data_d      = data_q;
      amt_d       = amt_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_err_d   = out_err_q;
      two_pass    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               op_d    = bus.in_op;
               data_d  = bus.in_data;
               amt_d   = bus.in_amount;
               state_d = S_PASS1;
            end
         end
         S_PASS1: begin
            acc_d     = sh_result;
            two_pass  = (amt_q != '0) &&
                        ((op_q == OP_ROL) || (op_q == OP_ROR) ||
                         ((op_q == OP_ASR) && data_q[WIDTH-1]));
            out_err_d = (op_q > OP_ASR);
            state_d   = two_pass ? S_PASS2 : S_DONE;
         end
         S_PASS2: begin
            // ASR pass 2 shifts all-ones right; its complement is the sign fill
            acc_d   = acc_q | ((op_q == OP_ASR) ? ~sh_result : sh_result);
            state_d = S_DONE;
         end
         S_DONE: begin
            // First DONE cycle loads the output register, then hold until taken
            if (!out_valid_q) begin
               out_data_d  = acc_q;
               out_valid_d = 1'b1;
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
               out_err_d   = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Shifter drive for the state being entered, so it is registered and valid all pass long
   always_comb begin
      sh_data_d   = '0;
      sh_amount_d = '0;
      sh_dir_d    = 1'b0;
      busy_d      = (state_d != S_IDLE);
      amt_comp    = (AMT_W+1)'(WIDTH) - {1'b0, amt_d};

      case (state_d)
         S_PASS1: begin
            sh_data_d   = data_d;
            sh_amount_d = (op_d > OP_ASR) ? '0 : amt_d;
            sh_dir_d    = (op_d == OP_LSL) || (op_d == OP_ROL);
         end
         S_PASS2: begin
            if (op_d == OP_ASR) begin
               sh_data_d   = '1;
               sh_amount_d = amt_d;
               sh_dir_d    = 1'b0;
            end else begin
               sh_data_d   = data_d;
               sh_amount_d = AMT_W'(amt_comp);
               sh_dir_d    = (op_d == OP_ROR);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         data_q      <= '0;
         amt_q       <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
         sh_data_q   <= '0;
         sh_amount_q <= '0;
         sh_dir_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         data_q      <= data_d;
         amt_q       <= amt_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_err_q   <= out_err_d;
         sh_data_q   <= sh_data_d;
         sh_amount_q <= sh_amount_d;
         sh_dir_q    <= sh_dir_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = clear_n && (state_q == S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_err   = out_err_q;
   assign sh_data       = sh_data_q;
   assign sh_amount     = sh_amount_q;
   assign sh_direction  = sh_dir_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: behavioural shifter, reference model and a scoreboard
// popped by an output monitor; directed cases followed by random requests.
module tb_shift_seq;
   localparam logic [2:0] LSL = 3'b000;
   localparam logic [2:0] LSR = 3'b001;
   localparam logic [2:0] ROL = 3'b010;
   localparam logic [2:0] ROR = 3'b011;
   localparam logic [2:0] ASR = 3'b100;

   typedef struct packed {
      logic [7:0] data;
      logic       err;
   } exp_t;

   logic       clk;
   logic       clear_n;
   logic [7:0] sh_data;
   logic [2:0] sh_amount;
   logic       sh_direction;
   logic [7:0] sh_result;
   logic       busy;

   int chk_total;
   int chk_pass;
   exp_t sb[$];

   shift_seq_if #(.WIDTH(8), .AMT_W(3)) bus_if ();

   shift_seq #(.WIDTH(8), .AMT_W(3)) dut (
      .clk          (clk),
      .clear_n      (clear_n),
      .bus          (bus_if.slave),
      .sh_data      (sh_data),
      .sh_amount    (sh_amount),
      .sh_direction (sh_direction),
      .sh_result    (sh_result),
      .busy         (busy)
   );

   // Plain logical shifter standing in for RLS803
   always_comb sh_result = sh_direction ? (sh_data << sh_amount) : (sh_data >> sh_amount);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_total++;
      if (act === exp) chk_pass++;
      else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [7:0] d, input logic [2:0] n);
      exp_t e;
      e.err  = 1'b0;
      e.data = d;
      case (op)
         LSL: e.data = d << n;
         LSR: e.data = d >> n;
         ROL: for (int i = 0; i < 8; i++) e.data[(i + int'(n)) % 8] = d[i];
         ROR: for (int i = 0; i < 8; i++) e.data[i] = d[(i + int'(n)) % 8];
         ASR: e.data = 8'($signed(d) >>> n);
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   function automatic int passes(input logic [2:0] op, input logic [7:0] d, input logic [2:0] n);
      if (n != 3'd0 && (op == ROL || op == ROR || (op == ASR && d[7]))) return 2;
      return 1;
   endfunction

   // Scoreboard monitor: every transfer must match the oldest outstanding request
   always @(negedge clk) begin
      exp_t e;
      if (clear_n && bus_if.out_valid && bus_if.out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("out_data", 32'(bus_if.out_data), 32'(e.data));
            check("out_err", 32'(bus_if.out_err), 32'(e.err));
         end
      end
   end

   task automatic wait_xfer(input bit rnd);
      bit done_x;
      done_x = 1'b0;
      for (int g = 0; g < 60 && !done_x; g++) begin
         bus_if.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(negedge clk);
         done_x = bus_if.out_valid && bus_if.out_ready;
         @(posedge clk);
         #1;
      end
      if (!done_x) check("xfer_timeout", 32'd0, 32'd1);
      bus_if.out_ready = 1'b1;
      check("valid_drop", 32'(bus_if.out_valid), 32'd0);
   endtask

   task automatic do_req(input logic [2:0] op, input logic [7:0] d, input logic [2:0] n,
                         input bit rnd, input bit do_xfer);
      int g;
      int lat;
      bit legal;
      @(negedge clk);
      bus_if.in_valid  = 1'b1;
      bus_if.in_op     = op;
      bus_if.in_data   = d;
      bus_if.in_amount = n;
      g = 0;
      while (!bus_if.in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!bus_if.in_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         bus_if.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      sb.push_back(model(op, d, n));
      #1;
      bus_if.in_valid = 1'b0;
      legal = (op <= ASR);
      check("pass1_dir", 32'(sh_direction), 32'(op == LSL || op == ROL));
      check("pass1_amt", 32'(sh_amount), 32'(legal ? n : 3'd0));
      check("pass1_data", 32'(sh_data), 32'(d));
      check("pass1_ready", 32'(bus_if.in_ready), 32'd0);
      lat = 0;
      while (!bus_if.out_valid && lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(passes(op, d, n) + 1));
      if (do_xfer) wait_xfer(rnd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", chk_pass, chk_total);
      $fatal(1, "watchdog");
   end

   initial begin
      chk_total        = 0;
      chk_pass         = 0;
      clear_n          = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_op     = 3'd0;
      bus_if.in_data   = 8'd0;
      bus_if.in_amount = 3'd0;
      bus_if.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      check("rst_out_data", 32'(bus_if.out_data), 32'd0);
      check("rst_out_err", 32'(bus_if.out_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
      check("rst_sh_data", 32'(sh_data), 32'd0);
      @(negedge clk);
      clear_n = 1'b1;
      #1;
      check("idle_in_ready", 32'(bus_if.in_ready), 32'd1);

      do_req(LSR, 8'hAA, 3'd2, 1'b0, 1'b1);
      do_req(ROL, 8'h81, 3'd3, 1'b0, 1'b1);
      do_req(ROR, 8'h01, 3'd1, 1'b0, 1'b1);
      do_req(ASR, 8'h90, 3'd2, 1'b0, 1'b1);
      do_req(ASR, 8'h50, 3'd2, 1'b0, 1'b1);
      do_req(ASR, 8'h80, 3'd7, 1'b0, 1'b1);
      do_req(ROL, 8'hAA, 3'd0, 1'b0, 1'b1);
      do_req(3'b111, 8'h3C, 3'd5, 1'b0, 1'b1);

      // Backpressure: result held, new requests ignored while stalled
      bus_if.out_ready = 1'b0;
      do_req(LSL, 8'hAA, 3'd3, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("bp_out_data", 32'(bus_if.out_data), 32'h50);
         check("bp_out_valid", 32'(bus_if.out_valid), 32'd1);
         check("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
         bus_if.in_valid = 1'b1;
         bus_if.in_op    = LSR;
         bus_if.in_data  = 8'($urandom);
         @(posedge clk);
         #1;
      end
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", 32'(bus_if.out_valid), 32'd0);
      check("bp_release_ready", 32'(bus_if.in_ready), 32'd1);
      do_req(LSR, 8'hF0, 3'd4, 1'b0, 1'b1);

      // Reset while ROL is in its second pass
      @(negedge clk);
      bus_if.in_valid  = 1'b1;
      bus_if.in_op     = ROL;
      bus_if.in_data   = 8'h81;
      bus_if.in_amount = 3'd3;
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("pass2_amt", 32'(sh_amount), 32'd5);
      check("pass2_dir", 32'(sh_direction), 32'd0);
      clear_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_out_valid", 32'(bus_if.out_valid), 32'd0);
      check("abort_out_data", 32'(bus_if.out_data), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_in_ready", 32'(bus_if.in_ready), 32'd0);
      @(negedge clk);
      clear_n = 1'b1;
      #1;
      check("abort_ready_back", 32'(bus_if.in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("abort_no_valid", 32'(bus_if.out_valid), 32'd0);
      end

      for (int i = 0; i < 60; i++) begin
         do_req(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom_range(0, 7)), 1'b1, 1'b1);
      end

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", chk_pass, chk_total);
      $finish;
   end
endmodule
